// File: rtl/mdu_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings, MDU state type
// and the M-extension decode helper.
package mdu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [31:0]     instr_t;

    localparam logic [6:0] OPCODE_R = 7'b0110011;
    localparam logic [6:0] M_INSTR  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MDU_DIV_CYCLES = XLEN;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

    function automatic logic is_m_instr(input instr_t instr);
        return (instr[6:0] == OPCODE_R) && (instr[31:25] == M_INSTR);
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per step.
// quo_nxt/rem_nxt expose the outcome of the step taken this cycle.
module mdu_div
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        // remainder < divisor always holds, so the trial difference fits in XLEN+1 bits
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (step) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: FSM, operand signing, multiply and result override.
// Define MDU_DIV_FAST_SPECIAL_EN to finish divide-by-zero/overflow in one cycle.
module mdu
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int DIV_CYCLES = MDU_DIV_CYCLES;
    localparam int CW         = $clog2(DIV_CYCLES);

`ifdef MDU_DIV_FAST_SPECIAL_EN
    localparam logic FAST_SPECIAL = 1'b1;
`else
    localparam logic FAST_SPECIAL = 1'b0;
`endif

    mdu_state_t      state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            dz_q, dz_d, ovf_q, ovf_d;

    logic            accept, dz_in, ovf_in, sgn_in;
    logic            div_load, div_step;
    logic [XLEN-1:0] dvd_in, dvs_in, quo_nxt, rem_nxt;
    logic [XLEN:0]   a33, b33;
    logic [2*XLEN-1:0] prod;

    function automatic logic [XLEN-1:0] special_res(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] a,
                                                    input logic dz);
        if (dz)
            return f3[1] ? a : '1;
        return f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    endfunction

    function automatic logic [XLEN-1:0] div_res(input logic [2:0] f3,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] r,
                                                input logic dz, input logic ovf);
        logic sgn;
        if (dz || ovf)
            return special_res(f3, a, dz);
        sgn = !f3[0];
        if (f3[1])
            return (sgn && a[XLEN-1]) ? -r : r;
        return (sgn && (a[XLEN-1] ^ b[XLEN-1])) ? -q : q;
    endfunction

    mdu_div u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (dvd_in),
        .divisor  (dvs_in),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_comb begin
        accept = start && !flush && (state_q == IDLE || state_q == DONE);
        sgn_in = !funct3[0];
        dz_in  = (rs2 == '0);
        ovf_in = sgn_in && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        dvd_in = (sgn_in && rs1[XLEN-1]) ? -rs1 : rs1;
        dvs_in = (sgn_in && rs2[XLEN-1]) ? -rs2 : rs2;

        // 33-bit extension per op; the 66-bit product is only needed to bit 63
        a33  = {(op_q != F3_MULHU) & a_q[XLEN-1], a_q};
        b33  = {((op_q == F3_MUL) || (op_q == F3_MULH)) & b_q[XLEN-1], b_q};
        prod = {{(XLEN-1){a33[XLEN]}}, a33} * {{(XLEN-1){b33[XLEN]}}, b33};

        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        div_load = 1'b0;
        div_step = 1'b0;

        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    if (accept) begin
                        op_d  = funct3;
                        a_d   = rs1;
                        b_d   = rs2;
                        dz_d  = dz_in;
                        ovf_d = ovf_in;
                        cnt_d = CW'(DIV_CYCLES - 1);
                        if (!funct3[2]) begin
                            state_d = MUL;
                            busy_d  = 1'b1;
                        end else if (FAST_SPECIAL && (dz_in || ovf_in)) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = special_res(funct3, rs1, dz_in);
                        end else begin
                            state_d  = DIV;
                            busy_d   = 1'b1;
                            div_load = 1'b1;
                        end
                    end
                end
                MUL: begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end
                DIV: begin
                    div_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = div_res(op_q, a_q, b_q, quo_nxt, rem_nxt, dz_q, ovf_q);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the RV32M multiply/divide unit.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

`ifdef MDU_DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    mdu dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Presents one request for a single edge; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        @(negedge clk);
        start  = 1'b0;
        funct3 = ~f3;
        rs1    = $urandom;
        rs2    = $urandom;
    endtask

    // Returns the cycle at which done is seen (-1 if it never comes) and the result.
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul_cycle1: busy=%b done=%b, want 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL mul_cycle2: busy=%b done=%b, want 0 1", busy, done);
        end
        checks++;
        if (result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_result: got %h want FFFFFFEB", result);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_cycle3: done=%b result=%h, want 0 FFFFFFEB", done, result);
        end
    endtask

    task automatic run_table(input string name, input logic [2:0] f3s[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [31:0] exps[], input int want_lat);
        int lat;
        logic [31:0] res;
        for (int i = 0; i < f3s.size(); i++) begin
            issue(f3s[i], as[i], bs[i]);
            wait_done(lat, res);
            checks++;
            if (res !== exps[i] || lat != want_lat) begin
                errors++;
                $display("FAIL %s[%0d]: result=%h lat=%0d, want %h lat=%0d",
                         name, i, res, lat, exps[i], want_lat);
            end
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  f3s[]  = '{F3_MULHU, F3_MULH, F3_MULHSU, F3_MUL};
        logic [31:0] as[]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        run_table("mulh", f3s, as, bs, exps, 2);
    endtask

    task automatic test_div();
        logic [2:0]  f3s[]  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
        logic [31:0] as[]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs[]   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exps[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
        run_table("div", f3s, as, bs, exps, 33);
    endtask

    task automatic test_special();
        logic [2:0]  f3s[]  = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM};
        logic [31:0] as[]   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] bs[]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exps[] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        run_table("special", f3s, as, bs, exps, SPECIAL_LAT);
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        logic [31:0] res;
        issue(F3_MUL, 32'd3, 32'd5);
        wait_done(lat, res);
        issue(F3_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd15) begin
            errors++;
            $display("FAIL flush_state: busy=%b done=%b result=%h, want 0 0 0000000F", busy, done, result);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_quiet: %0d active cycles after flush, want 0", seen);
        end
        issue(F3_MUL, 32'd3, 32'd4);
        wait_done(lat, res);
        checks++;
        if (res !== 32'd12 || lat != 2) begin
            errors++;
            $display("FAIL flush_then_mul: result=%h lat=%0d, want 0000000C lat=2", res, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int dones = 0;
        logic [31:0] res = '0;
        issue(F3_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start = 1'b1; funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd4;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) begin
                    lat = c;
                    res = result;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (res !== 32'd14 || lat != 33 || dones != 1) begin
            errors++;
            $display("FAIL ignore_start: result=%h lat=%0d dones=%0d, want 0000000E lat=33 dones=1",
                     res, lat, dones);
        end
    endtask

    task automatic test_back_to_back();
        issue(F3_MUL, 32'd7, 32'd6);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first: done=%b result=%h, want 1 0000002A", done, result);
        end
        start = 1'b1; funct3 = F3_MUL; rs1 = 32'd5; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: done=%b busy=%b, want 0 1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 32'd25) begin
            errors++;
            $display("FAIL b2b_second: done=%b result=%h, want 1 00000019", done, result);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        logic [31:0] res;
        issue(F3_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        issue(F3_REMU, 32'd100, 32'd7);
        wait_done(lat, res);
        checks++;
        if (res !== 32'd2 || lat != 33) begin
            errors++;
            $display("FAIL rst_then_div: result=%h lat=%0d, want 00000002 lat=33", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_ignore_start();
        test_back_to_back();
        test_rst_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
